// File: rtl/if_id_inst_queue_pkg.sv
// if_id_inst_queue_pkg: shared widths, NOP encoding and queue sizing for fetch/decode.
package if_id_inst_queue_pkg;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h00000000;
  localparam int DEPTH_DEF = 4;
  localparam int AW_DEF = 2;
endpackage

// File: rtl/if_id_inst_queue_mem.sv
// if_id_queue_mem: unreset register array, one synchronous write port, one asynchronous read port.
module if_id_queue_mem #(
  parameter int DEPTH = 4,
  parameter int AW = 2,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_inst_queue.sv
// if_id_inst_queue: circular instruction/PC buffer between fetch and decode with flush.
import if_id_inst_queue_pkg::*;
module if_id_inst_queue #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF,
  parameter int W = INST_W
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         in_valid,
  input  logic [W-1:0] in_inst,
  input  logic [W-1:0] in_pc,
  output logic         in_ready,
  input  logic         flush,
  output logic         out_valid,
  output logic [W-1:0] out_inst,
  output logic [W-1:0] out_pc,
  input  logic         out_ready,
  output logic [AW:0]  count
);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [2*W-1:0] rd_data;
  logic push, pop;
  assign in_ready = count_q != (AW+1)'(DEPTH);
  assign out_valid = count_q != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign count = count_q;
  // Empty queue shows a NOP so stale storage never reaches decode.
  assign out_inst = out_valid ? rd_data[2*W-1:W] : W'(NOP_INST);
  assign out_pc = out_valid ? rd_data[W-1:0] : '0;
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk)
    if (clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  if_id_queue_mem #(.DEPTH(DEPTH), .AW(AW), .DW(2*W)) u_mem (
    .clk(clk),
    .we(push & ~flush),
    .waddr(wr_ptr_q),
    .wdata({in_inst, in_pc}),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_if_id_inst_queue.sv
// tb_if_id_inst_queue: directed and random stimulus checked against a queue-based reference model.
module tb_if_id_inst_queue;
  logic clk = 0, clrn, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_inst, out_pc;
  logic [2:0] count;
  logic [63:0] q [$];
  int tests = 0, fails = 0;

  if_id_inst_queue dut (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc(out_pc), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag);
    logic [31:0] e_inst, e_pc;
    e_inst = q.size() > 0 ? q[0][63:32] : 32'h0;
    e_pc = q.size() > 0 ? q[0][31:0] : 32'h0;
    tests += 5;
    assert (count === 3'(q.size())) else begin fails++; $error("FAIL %s count: got %0d expected %0d", tag, count, q.size()); end
    assert (out_valid === (q.size() != 0)) else begin fails++; $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, q.size() != 0); end
    assert (in_ready === (q.size() != 4)) else begin fails++; $error("FAIL %s in_ready: got %b expected %b", tag, in_ready, q.size() != 4); end
    assert (out_inst === e_inst) else begin fails++; $error("FAIL %s out_inst: got %h expected %h", tag, out_inst, e_inst); end
    assert (out_pc === e_pc) else begin fails++; $error("FAIL %s out_pc: got %h expected %h", tag, out_pc, e_pc); end
  endtask

  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic rdy, input logic fl, input logic rst, input string tag);
    logic push_m, pop_m;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = rdy; flush = fl; clrn = rst;
    push_m = v && q.size() < 4;
    pop_m = rdy && q.size() > 0;
    @(posedge clk);
    #1;
    if (rst || fl) q.delete();
    else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back({inst, pc});
    end
    check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic v, r, f, rs;
    logic [31:0] inst;
    step(0, 'x, 'x, 0, 0, 1, "reset0");
    step(0, 'x, 'x, 0, 0, 1, "reset1");
    step(0, 'x, 'x, 1, 0, 0, "idle");
    step(1, 32'h20010005, 0, 0, 0, 0, "single_push");
    step(0, 'x, 'x, 1, 0, 0, "single_pop");
    for (int i = 0; i < 4; i++) step(1, 32'hA000_0000 + i, 4 * i, 0, 0, 0, "fill");
    step(1, 32'hA000_0004, 16, 0, 0, 0, "full_hold");
    step(1, 32'hA000_0004, 16, 1, 0, 0, "full_pop");
    step(1, 32'hA000_0004, 16, 0, 0, 0, "accept16");
    for (int i = 0; i < 5; i++) step(0, 'x, 'x, 1, 0, 0, "drain");
    for (int i = 0; i < 10; i++) step(1, 32'hB000_0000 + i, 4 * i, 1, 0, 0, "stream");
    step(0, 'x, 'x, 1, 0, 0, "stream_drain");
    for (int i = 0; i < 3; i++) step(1, 32'hC000_0000 + i, 40 + 4 * i, 0, 0, 0, "pre_flush");
    step(1, 32'hC000_0064, 100, 1, 1, 0, "flush");
    step(1, 32'hC000_00C8, 200, 0, 0, 0, "post_flush");
    step(0, 'x, 'x, 1, 0, 0, "post_flush_pop");
    for (int i = 0; i < 2; i++) step(1, 32'hD000_0000 + i, 300 + 4 * i, 0, 0, 0, "pre_reset");
    step(1, 32'hD000_00FF, 400, 1, 0, 1, "mid_reset");
    step(0, 'x, 'x, 1, 0, 0, "after_reset");
    step(1, 32'hD000_0100, 500, 0, 0, 0, "fresh_push");
    step(0, 'x, 'x, 1, 0, 0, "fresh_pop");
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      f = $urandom_range(0, 19) == 0;
      rs = $urandom_range(0, 59) == 0;
      inst = $urandom;
      step(v, v ? inst : 'x, v ? 32'($urandom) : 'x, r, f, rs, "random");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/if_id_inst_queue.md
Name: if_id_inst_queue

Overview:
- Instruction buffer between the fetch stage (PC register, PC+4 adder, instruction ROM) and the decode stage.
- Captures each fetched instruction together with the PC it was fetched from.
- Decouples decode stalls from fetch through a small circular FIFO with a valid/ready handshake on both sides.
- Supports a synchronous flush for branch/jump redirects; an empty queue presents a NOP (32'h00000000) to decode.

Parameters:
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- AW, 2, pointer width; equals log2(DEPTH).
- W, 32, instruction and PC width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clrn  input  1  reset; synchronous, active-high (asserted = 1) despite the name.
- in_valid  input  1  fetch presents a valid instruction this cycle.
- in_inst  input  W  fetched instruction word.
- in_pc  input  W  PC of in_inst.
- in_ready  output  1  queue accepts a push this cycle.
- flush  input  1  discard all queued entries (redirect).
- out_valid  output  1  head entry is valid.
- out_inst  output  W  head instruction; 0 when empty.
- out_pc  output  W  head PC; 0 when empty.
- out_ready  input  1  decode consumes the head this cycle.
- count  output  AW+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (clrn=1 at an edge): wr_ptr=0, rd_ptr=0, count=0, so out_valid=0, out_inst=0, out_pc=0, in_ready=1. Storage array is not reset. Reset overrides flush, push and pop.
- Derived signals:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
  - in_ready = (count != DEPTH), a function of registered count only; there is no combinational path from out_ready to in_ready.
  - out_valid = (count != 0).
  - out_inst and out_pc = storage[rd_ptr] when out_valid=1, else 0.
- Push: writes {in_inst, in_pc} to storage[wr_ptr]; wr_ptr increments modulo DEPTH (natural AW-bit wrap).
- Pop: rd_ptr increments modulo DEPTH.
- Count update: push only → +1; pop only → -1; push and pop together → unchanged. Pointers still advance.
- Latency: an entry pushed at edge N is visible on out_* after edge N (1-cycle fall-through from in_* to out_*). There is no same-cycle bypass when empty.
- Full (count=DEPTH): in_ready=0, even if out_ready=1 in the same cycle. in_valid is ignored, and fetch must hold its PC.
- Empty: out_ready is ignored, and no pointer movement occurs.
- Flush (flush=1 at an edge, clrn=0): wr_ptr=rd_ptr=count=0. Any push and pop in the same cycle are discarded. Next cycle out_valid=0 and in_ready=1.
- Illegal/ignored inputs: in_valid=0 with in_ready=1 → no state change. X on in_inst while in_valid=0 must not propagate to out_*.

Decomposition:
- Shared package/header holds:
  - INST_W = 32
  - NOP_INST = 32'h00000000
  - DEPTH/AW defaults, for reuse by the ID stage and hazard unit.
- One sub-module: if_id_queue_mem, a DEPTH x 2W register array with one synchronous write port and one asynchronous read port, no reset.
- Pointer/count control and output masking stay in if_id_inst_queue.

Test Plan:
- Reset, then idle: clrn=1 for 2 cycles, then 0 → count=0, out_valid=0, out_inst=0, out_pc=0, in_ready=1.
- Single pass: push inst=32'h20010005, pc=0 with out_ready=0 → next cycle out_valid=1, out_inst=32'h20010005, out_pc=0, count=1. Then out_ready=1 for 1 cycle → count=0, out_inst=0.
- Fill and full-stall: push pc=0,4,8,12 with out_ready=0 → count=4, in_ready=0. A 5th push (pc=16) held with in_valid=1 is not accepted. Pop once → in_ready=1 next cycle, then pc=16 is accepted; pop order is 0,4,8,12,16.
- Wrap and steady stream: in_valid=1 and out_ready=1 continuously for 10 pushes (pc=0..36 step 4) → count stays 1 after the first cycle. out_pc follows 0,4,...,36 in order, with pointers wrapping twice.
- Flush priority: with count=3, assert flush together with push (pc=100) and pop → next cycle count=0, out_valid=0. A subsequent push of pc=200 appears as the head, and pc=100 never appears.
- Reset mid-operation: with count=2, assert clrn together with flush=0, push=1, pop=1 → next cycle count=0, out_inst=0, in_ready=1. No stale entry is delivered afterward.
